// File: rtl/fir_pkg.sv
// Shared types and constants for the time-multiplexed FIR datapath.
// The accumulator width helper keeps the top and any sub-blocks in agreement.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_SAVE = 2'd2,
    ST_HOLD = 2'd3
  } fir_state_e;

  // Wide enough that TAPS full-scale products cannot overflow the accumulator.
  function automatic int fir_acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  localparam int HB_TAPS = 16;

  // Symmetric 16-tap half-band set, Q1.15.
  localparam logic signed [15:0] HB_COEF [HB_TAPS] = '{
    -16'sd81,   -16'sd134,  16'sd318,   16'sd645,
    -16'sd1257, -16'sd2262, 16'sd4522,  16'sd14633,
    16'sd14633, 16'sd4522,  -16'sd2262, -16'sd1257,
    16'sd645,   16'sd318,   -16'sd134,  -16'sd81
  };

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, arithmetic right shift by COEF_FRAC, then clamp to DATA_W signed.
// Purely combinational so it can sit in front of any output register.
module fir_round_sat #(
  parameter int ACC_W     = 36,
  parameter int DATA_W    = 16,
  parameter int COEF_FRAC = 15
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] result,
  output logic                     sat
);

  // One guard bit so adding the rounding constant cannot wrap.
  localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(1'b1) <<< (COEF_FRAC-1);
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W:0] biased_s;
  logic signed [ACC_W:0] shifted_s;

  // round, shift and clamp to the output range
  always_comb begin
    biased_s  = (ACC_W+1)'(acc) + HALF;
    shifted_s = biased_s >>> COEF_FRAC;
    if (shifted_s > SAT_MAX) begin
      result = SAT_MAX[DATA_W-1:0];
      sat    = 1'b1;
    end else if (shifted_s < SAT_MIN) begin
      result = SAT_MIN[DATA_W-1:0];
      sat    = 1'b1;
    end else begin
      result = shifted_s[DATA_W-1:0];
      sat    = 1'b0;
    end
  end

endmodule

// File: rtl/fir_mac_stream.sv
// Time-multiplexed FIR: one MAC per cycle over TAPS taps, programmable coefficients,
// ready/valid on both sides, rounded and saturated output with a clip flag.
module fir_mac_stream
  import fir_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 16,
  parameter int COEF_FRAC = 15
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [DATA_W-1:0]  out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sat,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic                      busy
);

  localparam int ADDR_W = $clog2(TAPS);
  localparam int ACC_W  = fir_acc_w(DATA_W, COEF_W, TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TAPS-1);
  localparam logic [ADDR_W:0]   TAPS_LIM  = (ADDR_W+1)'(TAPS);

  fir_state_e               state_r;
  logic signed [DATA_W-1:0] dly_r  [TAPS];
  logic signed [COEF_W-1:0] coef_r [TAPS];
  logic signed [ACC_W-1:0]  acc_r;
  logic [ADDR_W-1:0]        addr_r;

  logic signed [DATA_W-1:0] tap_s;
  logic signed [COEF_W-1:0] cf_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [DATA_W-1:0] rs_data_s;
  logic                     rs_sat_s;
  logic                     coef_wr_s;

  assign tap_s  = dly_r[addr_r];
  assign cf_s   = coef_r[addr_r];
  assign prod_s = PROD_W'(tap_s) * PROD_W'(cf_s);

  // Out-of-range indices only exist when TAPS is not a power of two.
  assign coef_wr_s = (state_r == ST_IDLE) && coef_we && ({1'b0, coef_addr} < TAPS_LIM);

  fir_round_sat #(
    .ACC_W     (ACC_W),
    .DATA_W    (DATA_W),
    .COEF_FRAC (COEF_FRAC)
  ) u_round_sat (
    .acc    (acc_r),
    .result (rs_data_s),
    .sat    (rs_sat_s)
  );

  // coefficient bank, writable only while idle
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) coef_r[i] <= '0;
    end else if (coef_wr_s) begin
      coef_r[coef_addr] <= coef_data;
    end
  end

  // control FSM with delay line, accumulator and registered handshake outputs
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      acc_r     <= '0;
      addr_r    <= '0;
      for (int i = 0; i < TAPS; i++) dly_r[i] <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            dly_r[0] <= in_data;
            for (int i = 1; i < TAPS; i++) dly_r[i] <= dly_r[i-1];
            acc_r    <= '0;
            addr_r   <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_r  <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc_r <= acc_r + ACC_W'(prod_s);
          if (addr_r == LAST_ADDR) begin
            addr_r  <= '0;
            state_r <= ST_SAVE;
          end else begin
            addr_r <= addr_r + ADDR_W'(1);
          end
        end
        ST_SAVE: begin
          out_data  <= rs_data_s;
          out_sat   <= rs_sat_s;
          out_valid <= 1'b1;
          state_r   <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_stream.sv
// Directed bench for fir_mac_stream: a 16-tap instance for the main scenarios and an
// 18-tap instance for out-of-range coefficient addresses.
module tb_fir_mac_stream;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst;

  logic signed [15:0] in_data, out_data, coef_data;
  logic in_valid, in_ready, out_valid, out_ready, out_sat, coef_we, busy;
  logic [3:0] coef_addr;

  logic signed [15:0] b_in_data, b_out_data, b_coef_data;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sat, b_coef_we, b_busy;
  logic [4:0] b_coef_addr;

  int n_checks = 0;
  int n_fail   = 0;

  fir_mac_stream #(.DATA_W(16), .COEF_W(16), .TAPS(16), .COEF_FRAC(15)) dut (
    .clock(clock), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sat(out_sat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy)
  );

  fir_mac_stream #(.DATA_W(16), .COEF_W(16), .TAPS(18), .COEF_FRAC(15)) dut18 (
    .clock(clock), .rst(rst),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sat(b_out_sat),
    .coef_we(b_coef_we), .coef_addr(b_coef_addr), .coef_data(b_coef_data), .busy(b_busy)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_coef(input logic [3:0] a, input logic signed [15:0] d);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    step();
    coef_we = 1'b0;
  endtask

  task automatic b_write_coef(input logic [4:0] a, input logic signed [15:0] d);
    b_coef_we = 1'b1; b_coef_addr = a; b_coef_data = d;
    step();
    b_coef_we = 1'b0;
  endtask

  task automatic program_ramp();
    for (int k = 0; k < 16; k++) write_coef(4'(k), 16'((k + 1) * 1024));
  endtask

  // One full pass on the 16-tap instance with out_ready held high.
  task automatic run_sample(input logic signed [15:0] d, output logic signed [15:0] y, output logic s);
    int t = 0;
    while (!in_ready && t < 50) begin step(); t++; end
    in_data = d; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin step(); t++; end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL run_sample_timeout: out_valid=%b required 1", out_valid);
    end
    y = out_data; s = out_sat;
    step();
  endtask

  task automatic b_run_sample(input logic signed [15:0] d, output logic signed [15:0] y);
    int t = 0;
    while (!b_in_ready && t < 50) begin step(); t++; end
    b_in_data = d; b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    t = 0;
    while (!b_out_valid && t < 50) begin step(); t++; end
    n_checks++;
    if (b_out_valid !== 1'b1) begin
      n_fail++; $display("FAIL b_run_sample_timeout: out_valid=%b required 1", b_out_valid);
    end
    y = b_out_data;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    b_coef_we = 1'b0; b_coef_addr = '0; b_coef_data = '0;
    repeat (3) step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (out_data !== 16'sd0) begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat: got %b want 0", out_sat); end
    n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_in_ready: got %b want 1", b_in_ready); end
    rst = 1'b0;
    step();
  endtask

  // Assumes ramp coefficients and zero history; leaves zero history behind.
  task automatic test_impulse(input string tag);
    logic signed [15:0] y, exp_y;
    logic s;
    for (int k = 0; k <= 16; k++) begin
      run_sample((k == 0) ? 16'sd16384 : 16'sd0, y, s);
      exp_y = (k < 16) ? 16'((k + 1) * 512) : 16'sd0;
      n_checks++;
      if (y !== exp_y || s !== 1'b0) begin
        n_fail++; $display("FAIL %s[%0d]: out_data=%0d sat=%b want %0d sat=0", tag, k, y, s, exp_y);
      end
    end
  endtask

  task automatic test_latency();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_c0_in_ready: got %b want 1", in_ready); end
    in_data = 16'sd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lat_in_ready c%0d: got %b want 0", cyc, in_ready); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy c%0d: got %b want 1", cyc, busy); end
      n_checks++; if (out_valid !== (cyc == 18)) begin n_fail++; $display("FAIL lat_out_valid c%0d: got %b want %b", cyc, out_valid, cyc == 18); end
      step();
    end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_c19_in_ready: got %b want 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lat_c19_busy: got %b want 0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_c19_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int t = 0;
    out_ready = 1'b0;
    in_data = 16'sd16384; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    while (!out_valid && t < 50) begin step(); t++; end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout: out_valid=%b want 1", out_valid); end
    in_data = 16'sd1000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 16'sd512 || out_sat !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: valid=%b data=%0d sat=%b in_ready=%b want 1/512/0/0",
                           i, out_valid, out_data, out_sat, in_ready);
      end
      step();
    end
    in_data = -16'sd16384; out_ready = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: in_ready=%b busy=%b valid=%b want 1/0/0", in_ready, busy, out_valid);
    end
    step();
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_accept_busy: got %b want 1", busy); end
    t = 0;
    while (!out_valid && t < 50) begin step(); t++; end
    // -16384*1024 + 16384*2048 = 2^24 -> 512; a taken 1000 would disturb s[1]
    n_checks++; if (out_data !== 16'sd512) begin n_fail++; $display("FAIL bp_next: out_data=%0d want 512", out_data); end
    step();
  endtask

  task automatic test_coef_protect();
    logic signed [15:0] y;
    logic s;
    int t = 0;
    in_data = 16'sd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    coef_we = 1'b1; coef_addr = 4'd3; coef_data = 16'sd0;
    step(); step();
    coef_addr = 4'd0; coef_data = -16'sd7;
    step(); step();
    coef_we = 1'b0;
    while (!out_valid && t < 50) begin step(); t++; end
    step();
    for (int k = 0; k < 15; k++) run_sample(16'sd0, y, s);
    test_impulse("protect_impulse");
    // write and accept in the same idle cycle: the new c[0] applies to this pass
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 16'sd2048;
    in_data = 16'sd16384; in_valid = 1'b1;
    step();
    coef_we = 1'b0; in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin step(); t++; end
    n_checks++; if (out_data !== 16'sd1024) begin n_fail++; $display("FAIL same_cycle_write: out_data=%0d want 1024", out_data); end
    step();
  endtask

  task automatic test_saturation();
    logic signed [15:0] y;
    logic s;
    for (int k = 0; k < 16; k++) write_coef(4'(k), 16'sd32767);
    for (int k = 0; k < 16; k++) run_sample(16'sd32767, y, s);
    n_checks++; if (y !== 16'sd32767 || s !== 1'b1) begin n_fail++; $display("FAIL sat_pos: out_data=%0d sat=%b want 32767 sat=1", y, s); end
    for (int k = 0; k < 16; k++) run_sample(-16'sd32768, y, s);
    n_checks++; if (y !== -16'sd32768 || s !== 1'b1) begin n_fail++; $display("FAIL sat_neg: out_data=%0d sat=%b want -32768 sat=1", y, s); end
    write_coef(4'd0, 16'sd1);
    for (int k = 1; k < 16; k++) write_coef(4'(k), 16'sd0);
    run_sample(16'sd16384, y, s);
    n_checks++; if (y !== 16'sd1 || s !== 1'b0) begin n_fail++; $display("FAIL round_half: out_data=%0d sat=%b want 1 sat=0", y, s); end
    run_sample(-16'sd16384, y, s);
    n_checks++; if (y !== 16'sd0 || s !== 1'b0) begin n_fail++; $display("FAIL round_neg_half: out_data=%0d sat=%b want 0 sat=0", y, s); end
    run_sample(-16'sd16385, y, s);
    n_checks++; if (y !== -16'sd1 || s !== 1'b0) begin n_fail++; $display("FAIL round_neg: out_data=%0d sat=%b want -1 sat=0", y, s); end
  endtask

  task automatic test_reset_mid_mac();
    logic signed [15:0] y, exp_y;
    logic s;
    int seen = 0;
    in_data = 16'sd12345; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async: valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid !== 1'b0) seen++;
      step();
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midrst_no_valid: out_valid high %0d cycles want 0", seen); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    // coefficients were cleared, so the impulse sample alone yields 0
    run_sample(16'sd16384, y, s);
    n_checks++; if (y !== 16'sd0) begin n_fail++; $display("FAIL midrst_coef_clear: out_data=%0d want 0", y); end
    program_ramp();
    for (int k = 1; k <= 16; k++) begin
      run_sample(16'sd0, y, s);
      exp_y = (k < 16) ? 16'((k + 1) * 512) : 16'sd0;
      n_checks++; if (y !== exp_y) begin n_fail++; $display("FAIL midrst_tail[%0d]: out_data=%0d want %0d", k, y, exp_y); end
    end
    test_impulse("midrst_impulse");
  endtask

  task automatic test_coef_range();
    logic signed [15:0] y, exp_y;
    for (int k = 0; k < 18; k++) b_write_coef(5'(k), 16'((k + 1) * 1024));
    b_write_coef(5'd18, 16'sd32767);
    b_write_coef(5'd20, 16'sd32767);
    b_write_coef(5'd31, -16'sd32768);
    for (int k = 0; k <= 18; k++) begin
      b_run_sample((k == 0) ? 16'sd16384 : 16'sd0, y);
      exp_y = (k < 18) ? 16'((k + 1) * 512) : 16'sd0;
      n_checks++; if (y !== exp_y) begin n_fail++; $display("FAIL taps18_impulse[%0d]: out_data=%0d want %0d", k, y, exp_y); end
    end
  endtask

  initial begin
    test_reset();
    program_ramp();
    test_impulse("impulse");
    test_latency();
    test_backpressure();
    test_coef_protect();
    test_saturation();
    test_reset_mid_mac();
    test_coef_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
